tx_serializer: RTL and testbench

- D-PHY transmit-side counterpart of the lane deserializer. Takes aligned 8-bit bytes for up to 4 lanes through a valid/ready handshake and serializes them LSB-first, one bit per bit-clock cycle.
- Wraps each burst with an HS-zero leader, the sync byte 0xB8, and an inverted-last-bit trailer.
- Generates a divide-by-8 byte clock for the byte-domain producer.
- Sits between the CSI-2 TX lane-distribution logic and the PHY output drivers.

---
 rtl/dphy_pkg.sv | 17 +
 rtl/tx_serializer_if.sv | 11 +
 rtl/tx_serializer_lane_shifter.sv | 47 ++++
 rtl/tx_serializer.sv | 121 ++++++++++++
 tb/tb_tx_serializer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dphy_pkg.sv
// Shared types and constants for the D-PHY transmit serializer.
package dphy_pkg;
  localparam int         NUM_LANES = 4;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {IDLE, HS_ZERO, SYNC, DATA, TRAIL} tx_state_e;
  typedef enum logic [1:0] {SEL_ZERO, SEL_SYNC, SEL_DATA, SEL_TRAIL} lane_sel_e;

  function automatic lane_sel_e state_to_sel(tx_state_e s);
    case (s)
      SYNC:    return SEL_SYNC;
      DATA:    return SEL_DATA;
      TRAIL:   return SEL_TRAIL;
      default: return SEL_ZERO;
    endcase
  endfunction
endpackage

// File: rtl/tx_serializer_if.sv
// Byte-domain producer handshake into the serializer.
interface tx_serializer_if;
  import dphy_pkg::*;
  logic [1:0]                active_lanes;
  logic [NUM_LANES-1:0][7:0] byte_data;
  logic                      byte_valid;
  logic                      byte_ready;

  modport master (output active_lanes, byte_data, byte_valid, input byte_ready);
  modport slave  (input active_lanes, byte_data, byte_valid, output byte_ready);
endinterface

// File: rtl/tx_serializer_lane_shifter.sv
// One lane: payload shift register, last-bit capture and output source mux.
module tx_lane_shifter
  import dphy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  lane_sel_e  sel_i,
  input  logic [2:0] bit_cnt_i,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       cap_i,
  input  logic [7:0] data_i,
  output logic       bit_o
);
  logic [7:0] sh_q, sh_d;
  logic       last_q, last_d;
  logic       bit_raw;

  always_comb begin
    bit_raw = 1'b0;
    case (sel_i)
      SEL_SYNC:  bit_raw = SYNC_BYTE[bit_cnt_i];
      SEL_DATA:  bit_raw = sh_q[0];
      SEL_TRAIL: bit_raw = ~last_q;
      default:   bit_raw = 1'b0;
    endcase
    bit_o = en_i & bit_raw;

    sh_d   = sh_q;
    last_d = last_q;
    // load wins over shift so back-to-back bytes stay contiguous
    if (en_i && load_i)  sh_d = data_i;
    else if (shift_i)    sh_d = {1'b0, sh_q[7:1]};
    if (en_i && cap_i)   last_d = bit_raw;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_q   <= '0;
      last_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/tx_serializer.sv
// D-PHY HS transmit serializer: leader, sync, LSB-first payload, trailer per lane.
module tx_serializer
  import dphy_pkg::*;
#(
  parameter int HS_ZERO_BYTES = 2,
  parameter int TRAIL_BYTES   = 1
) (
  input  logic bit_clk_i,
  input  logic rst_ni,
  tx_serializer_if.slave byte_if,
  output logic byte_clk_o,
  output logic bit_data_lane0_o,
  output logic bit_data_lane1_o,
  output logic bit_data_lane2_o,
  output logic bit_data_lane3_o,
  output logic hs_active_lane0_o,
  output logic hs_active_lane1_o,
  output logic hs_active_lane2_o,
  output logic hs_active_lane3_o
);
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 byte_clk_q;
  tx_state_e            state_q, state_d;
  logic [3:0]           slot_q, slot_d;
  logic [1:0]           lanes_q, lanes_d;
  logic                 load, cap, ready, slot_end;
  logic [NUM_LANES-1:0] lane_en, bit_data;
  lane_sel_e            sel;

  assign bit_cnt_d = bit_cnt_q + 3'd1;
  assign slot_end  = (bit_cnt_q == 3'd7);
  assign sel       = state_to_sel(state_q);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    lanes_d = lanes_q;
    load    = 1'b0;
    cap     = 1'b0;
    ready   = 1'b0;
    if (slot_end) begin
      case (state_q)
        IDLE: if (byte_if.byte_valid) begin
          lanes_d = byte_if.active_lanes;
          slot_d  = '0;
          state_d = HS_ZERO;
        end
        HS_ZERO: begin
          slot_d = slot_q + 4'd1;
          if (slot_q == 4'(HS_ZERO_BYTES - 1)) begin
            slot_d  = '0;
            state_d = SYNC;
          end
        end
        SYNC, DATA: begin
          ready = 1'b1;
          if (byte_if.byte_valid) begin
            load    = 1'b1;
            state_d = DATA;
          end else begin
            // the bit on the wire right now is the burst's last bit
            cap     = 1'b1;
            slot_d  = '0;
            state_d = TRAIL;
          end
        end
        TRAIL: begin
          slot_d = slot_q + 4'd1;
          if (slot_q == 4'(TRAIL_BYTES - 1)) begin
            slot_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge bit_clk_i) begin
    if (!rst_ni) begin
      bit_cnt_q  <= '0;
      byte_clk_q <= 1'b0;
      state_q    <= IDLE;
      slot_q     <= '0;
      lanes_q    <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_clk_q <= ~bit_cnt_d[2];
      state_q    <= state_d;
      slot_q     <= slot_d;
      lanes_q    <= lanes_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_en[i] = (state_q != IDLE) && (lanes_q >= 2'(i));
    tx_lane_shifter u_shf (
      .clk_i     (bit_clk_i),
      .rst_ni    (rst_ni),
      .en_i      (lane_en[i]),
      .sel_i     (sel),
      .bit_cnt_i (bit_cnt_q),
      .load_i    (load),
      .shift_i   (state_q == DATA),
      .cap_i     (cap),
      .data_i    (byte_if.byte_data[i]),
      .bit_o     (bit_data[i])
    );
  end

  assign byte_if.byte_ready = ready;
  assign byte_clk_o         = byte_clk_q;
  assign bit_data_lane0_o   = bit_data[0];
  assign bit_data_lane1_o   = bit_data[1];
  assign bit_data_lane2_o   = bit_data[2];
  assign bit_data_lane3_o   = bit_data[3];
  assign hs_active_lane0_o  = lane_en[0];
  assign hs_active_lane1_o  = lane_en[1];
  assign hs_active_lane2_o  = lane_en[2];
  assign hs_active_lane3_o  = lane_en[3];
endmodule

// File: tb/tb_tx_serializer.sv
// Randomized scoreboard bench for tx_serializer against a per-burst bit-stream model.
module tb_tx_serializer;
  localparam int HZ = 2;
  localparam int TB = 1;

  typedef struct {
    int         cyc;
    logic [3:0] hs;
    logic [3:0] d;
    logic       rdy;
  } exp_t;

  logic bit_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic byte_clk;
  logic bd0, bd1, bd2, bd3, hs0, hs1, hs2, hs3;

  tx_serializer_if byte_if ();

  tx_serializer #(.HS_ZERO_BYTES(HZ), .TRAIL_BYTES(TB)) dut (
    .bit_clk_i         (bit_clk),
    .rst_ni            (rst_n),
    .byte_if           (byte_if.slave),
    .byte_clk_o        (byte_clk),
    .bit_data_lane0_o  (bd0),
    .bit_data_lane1_o  (bd1),
    .bit_data_lane2_o  (bd2),
    .bit_data_lane3_o  (bd3),
    .hs_active_lane0_o (hs0),
    .hs_active_lane1_o (hs1),
    .hs_active_lane2_o (hs2),
    .hs_active_lane3_o (hs3)
  );

  always #5 bit_clk = ~bit_clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          prev_end = -1;
  bit          mon_en = 1'b0;
  exp_t        expq[$];
  logic [31:0] pay[16];

  // cycle index since reset release; its value mod 8 is the slot bit position
  always @(posedge bit_clk) cyc <= rst_n ? cyc + 1 : 0;

  always @(negedge bit_clk) begin : mon
    logic [3:0] oh, od;
    logic       bc;
    exp_t       e;
    if (mon_en && rst_n) begin
      oh = {hs3, hs2, hs1, hs0};
      od = {bd3, bd2, bd1, bd0};
      bc = (cyc == 0) ? 1'b0 : ((cyc % 8) < 4);
      checks++;
      if (byte_clk !== bc) begin
        errors++;
        $display("FAIL byte_clk cyc=%0d got=%b want=%b", cyc, byte_clk, bc);
      end
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        errors++;
        $display("FAIL missing_output cyc=%0d expected at cyc=%0d", cyc, expq[0].cyc);
        void'(expq.pop_front());
      end
      checks++;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        if (oh !== e.hs || od !== e.d || byte_if.byte_ready !== e.rdy) begin
          errors++;
          $display("FAIL burst cyc=%0d got hs=%h d=%h rdy=%b want hs=%h d=%h rdy=%b",
                   cyc, oh, od, byte_if.byte_ready, e.hs, e.d, e.rdy);
        end
      end else if (oh !== 4'h0 || od !== 4'h0 || byte_if.byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc=%0d got hs=%h d=%h rdy=%b want all zero",
                 cyc, oh, od, byte_if.byte_ready);
      end
    end
  end

  // One burst of k bytes per lane from pay[0..k-1]; expected wire stream is
  // built from the framing rules and pushed before the DUT can produce it.
  task automatic run_burst(input int nl, input int k, input int align,
                           input bit stall, input int gap);
    int s, L, j, n, slot, b;
    bit pend;
    exp_t e;
    logic [7:0] sb;
    sb = 8'hB8;
    @(negedge bit_clk);
    if (align >= 0)
      for (n = 0; n < 8 && (cyc % 8) != align; n++) @(negedge bit_clk);
    byte_if.active_lanes = 2'(nl);
    byte_if.byte_data    = pay[0];
    byte_if.byte_valid   = 1'b1;
    s = (cyc > prev_end) ? cyc : prev_end + 1;
    while (s % 8 != 7) s++;
    L = 8 * (HZ + 1 + k + TB);
    for (int t = 0; t < L; t++) begin
      slot  = t / 8;
      b     = t % 8;
      e.cyc = s + 1 + t;
      e.rdy = (b == 7) && (slot >= HZ) && (slot <= HZ + k);
      for (int ln = 0; ln < 4; ln++) begin
        e.hs[ln] = (ln <= nl);
        if (ln > nl)              e.d[ln] = 1'b0;
        else if (slot < HZ)       e.d[ln] = 1'b0;
        else if (slot == HZ)      e.d[ln] = sb[b];
        else if (slot <= HZ + k)  e.d[ln] = pay[slot - HZ - 1][ln * 8 + b];
        else                      e.d[ln] = ~pay[k - 1][ln * 8 + 7];
      end
      expq.push_back(e);
    end
    prev_end = s + L;
    j = 0;
    pend = 1'b0;
    for (n = 0; n < 400 && !(j == k && !pend); n++) begin
      @(negedge bit_clk);
      if (pend) begin
        pend = 1'b0;
        if (j == k) byte_if.byte_valid = 1'b0;
        else begin
          byte_if.byte_data    = pay[j];
          byte_if.active_lanes = 2'($urandom_range(0, 3));
        end
      end
      if (j < k && byte_if.byte_ready && byte_if.byte_valid) begin
        j++;
        pend = 1'b1;
      end
    end
    checks++;
    if (j != k || pend) begin
      errors++;
      $display("FAIL handshake_timeout transfers=%0d want=%0d", j, k);
      byte_if.byte_valid = 1'b0;
    end
    if (stall) begin
      for (n = 0; n < 16 && !byte_if.byte_ready; n++) @(negedge bit_clk);
    end else begin
      while (cyc <= prev_end + gap) @(negedge bit_clk);
    end
  endtask

  initial begin
    byte_if.active_lanes = '0;
    byte_if.byte_data    = '0;
    byte_if.byte_valid   = 1'b0;
    repeat (3) @(posedge bit_clk);
    @(negedge bit_clk);
    checks++;
    if ({hs3, hs2, hs1, hs0, bd3, bd2, bd1, bd0, byte_clk, byte_if.byte_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state got hs=%b%b%b%b d=%b%b%b%b bc=%b rdy=%b want zero",
               hs3, hs2, hs1, hs0, bd3, bd2, bd1, bd0, byte_clk, byte_if.byte_ready);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (64) @(negedge bit_clk);

    // four lanes, one byte each
    pay[0] = {8'h01, 8'hFF, 8'h3C, 8'hA5};
    run_burst(3, 1, -1, 1'b0, 5);

    // lane0 only, three back-to-back bytes; other lanes carry junk
    for (int i = 0; i < 3; i++) pay[i] = {$urandom_range(0, 16777215), 8'h00} >> 8 << 8;
    pay[0][7:0] = 8'h12;
    pay[1][7:0] = 8'h34;
    pay[2][7:0] = 8'h56;
    run_burst(0, 3, -1, 1'b0, 3);

    // valid raised at bit position 2 in idle
    pay[0] = $urandom;
    run_burst(1, 1, 2, 1'b0, 0);

    // valid low at one load point, then the next byte immediately
    pay[0] = $urandom;
    pay[1] = $urandom;
    run_burst(2, 2, -1, 1'b1, 0);
    pay[0] = $urandom;
    run_burst(2, 1, -1, 1'b0, 2);

    for (int r = 0; r < 24; r++) begin
      int k;
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) pay[i] = $urandom;
      run_burst($urandom_range(0, 3), k,
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1,
                ($urandom_range(0, 3) == 0), $urandom_range(0, 20));
    end
    while (cyc <= prev_end) @(negedge bit_clk);

    // reset pulse in the middle of a payload byte
    mon_en = 1'b0;
    @(negedge bit_clk);
    pay[0] = $urandom;
    byte_if.active_lanes = 2'd3;
    byte_if.byte_data    = pay[0];
    byte_if.byte_valid   = 1'b1;
    for (int n = 0; n < 64 && !byte_if.byte_ready; n++) @(negedge bit_clk);
    repeat (3) @(negedge bit_clk);
    checks++;
    if ({hs3, hs2, hs1, hs0} !== 4'hF) begin
      errors++;
      $display("FAIL pre_reset_active got=%b%b%b%b want=1111", hs3, hs2, hs1, hs0);
    end
    rst_n = 1'b0;
    byte_if.byte_valid = 1'b0;
    @(negedge bit_clk);
    rst_n = 1'b1;
    checks++;
    if ({hs3, hs2, hs1, hs0, bd3, bd2, bd1, bd0, byte_clk, byte_if.byte_ready} !== '0 || cyc != 0) begin
      errors++;
      $display("FAIL mid_burst_reset got hs=%b%b%b%b d=%b%b%b%b bc=%b rdy=%b want zero",
               hs3, hs2, hs1, hs0, bd3, bd2, bd1, bd0, byte_clk, byte_if.byte_ready);
    end
    expq.delete();
    prev_end = -1;
    mon_en   = 1'b1;
    repeat (40) @(negedge bit_clk);

    pay[0] = $urandom;
    run_burst(3, 1, -1, 1'b0, 4);
    for (int n = 0; n < 2000 && expq.size() > 0; n++) @(negedge bit_clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
